// File: rtl/ahb_rr_arbiter_if.sv
// Bus-side signal bundle for ahb_rr_arbiter.
// The master modport drives requests and transfer status toward the arbiter.
// The slave modport is the arbiter's own view of the bundle.
interface ahb_rr_arbiter_if #(
    parameter int NUM_MST = 4
);
    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    logic [NUM_MST-1:0] hbusreq;
    logic [NUM_MST-1:0] hlock;
    logic [1:0]         htrans;
    logic [2:0]         hburst;
    logic               hready;
    logic [1:0]         hresp;
    logic [NUM_MST-1:0] hsplit;
    logic [NUM_MST-1:0] hgrant;
    logic [MW-1:0]      hmaster;
    logic [MW-1:0]      hmasterd;
    logic               hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
        input  hgrant, hmaster, hmasterd, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
        output hgrant, hmaster, hmasterd, hmastlock
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with a default master.
// It does not re-arbitrate inside fixed-length bursts or while the owner holds HLOCK.
// Define ARB_SPLIT_EN to mask SPLIT masters until their HSPLIT release arrives.
// Without ARB_SPLIT_EN, SPLIT is treated exactly like RETRY.
module ahb_rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input logic            hclk,
    input logic            hreset,
    ahb_rr_arbiter_if.slave bus
);
    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam logic [NUM_MST-1:0] ONE_HOT0  = NUM_MST'(1);
    localparam logic [NUM_MST-1:0] DEF_GRANT = ONE_HOT0 << DEF_MST;
    localparam logic [MW-1:0]      DEF_IDX   = MW'(DEF_MST);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    // last_owner always holds the index of the current HGRANT.
    // It also serves as the round-robin search origin.
    logic [MW-1:0]      last_owner;
    logic [4:0]         beat_cnt;
    logic [NUM_MST-1:0] split_mask;
    logic [NUM_MST-1:0] eligible;
    logic [MW-1:0]      winner;
    logic [MW-1:0]      idx;
    logic               found;
    logic [4:0]         rem;
    logic               arb_point;
    htrans_e            trans;

    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            3'd2, 3'd3: burst_len = 5'd4;
            3'd4, 3'd5: burst_len = 5'd8;
            3'd6, 3'd7: burst_len = 5'd16;
            default:    burst_len = 5'd0;   // SINGLE and undefined-length INCR
        endcase
    endfunction

    // Find the round-robin winner, and decide whether this edge is an arbitration point.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path infers a latch.
        trans  = htrans_e'(bus.htrans);
        rem    = 5'd0;
        winner = DEF_IDX;
        found  = 1'b0;
        idx    = '0;
        // rem counts the fixed-burst beats still to be accepted, including the current beat.
        case (trans)
            TR_NONSEQ:      rem = burst_len(bus.hburst);
            TR_SEQ, TR_BUSY: rem = beat_cnt;
            default:        rem = 5'd0;
        endcase
        arb_point = bus.hready && !bus.hlock[last_owner] && (rem <= 5'd1);
        eligible  = bus.hbusreq & ~split_mask;
        for (int k = 1; k <= NUM_MST; k++) begin
            idx = MW'((int'(last_owner) + k) % NUM_MST);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Register a new grant at each arbitration point.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            bus.hgrant <= DEF_GRANT;
            last_owner <= DEF_IDX;
        end else if (arb_point) begin
            // NOTE: registers take non-blocking assignments so every block samples pre-edge values.
            bus.hgrant <= ONE_HOT0 << winner;
            last_owner <= winner;
        end
    end

    // Advance the address-phase and data-phase owners only on accepted cycles.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            bus.hmaster   <= DEF_IDX;
            bus.hmasterd  <= DEF_IDX;
            bus.hmastlock <= 1'b0;
        end else if (bus.hready) begin
            bus.hmaster   <= last_owner;
            bus.hmasterd  <= bus.hmaster;
            bus.hmastlock <= bus.hlock[last_owner];
        end
    end

    // Track fixed-burst beats still outstanding, after accounting for each accepted beat.
    // A new NONSEQ or IDLE restarts the count, which covers early termination.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            beat_cnt <= 5'd0;
        end else if (bus.hready) begin
            case (trans)
                TR_NONSEQ: beat_cnt <= (burst_len(bus.hburst) == 5'd0) ? 5'd0
                                                                         : burst_len(bus.hburst) - 5'd1;
                TR_SEQ:    beat_cnt <= (beat_cnt == 5'd0) ? 5'd0 : beat_cnt - 5'd1;
                TR_IDLE:   beat_cnt <= 5'd0;
                default:   beat_cnt <= beat_cnt;
            endcase
        end
    end

`ifdef ARB_SPLIT_EN
    localparam logic [1:0] RESP_SPLIT = 2'd3;
    logic [NUM_MST-1:0] split_set;

    assign split_set = (bus.hresp == RESP_SPLIT && !bus.hready) ? (ONE_HOT0 << bus.hmasterd) : '0;

    // Mask a master when a SPLIT response starts, and unmask it when HSPLIT releases it.
    // If both happen on the same edge, the new SPLIT wins.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            split_mask <= '0;
        end else begin
            split_mask <= (split_mask & ~bus.hsplit) | split_set;
        end
    end
`else
    logic unused_split;
    assign split_mask   = '0;
    assign unused_split = ^{bus.hsplit, bus.hresp};
`endif
endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Parametrised AHB bus arbiter for NUM_MST masters, the next-generation replacement for the fixed four-master arbiter in the AHB GPIO/RAM subsystem. It is round-robin with a default master, burst-aware (no re-arbitration inside fixed-length bursts), lock-aware, and optionally SPLIT-aware. It drives HGRANT to the masters and HMASTER/HMASTERD/HMASTLOCK to the master-to-slave mux and the slaves.

## Interface
- NUM_MST, 4: number of masters, 2..16; MW = clog2(NUM_MST), min 1.
- DEF_MST, 0: default master index, granted when no request is pending.
- HCLK  input  1  bus clock; all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HBUSREQ  input  NUM_MST  per-master bus request.
- HLOCK  input  NUM_MST  per-master locked-transfer request.
- HTRANS  input  2  muxed transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  input  3  muxed burst type.
- HREADY  input  1  muxed slave ready.
- HRESP  input  2  muxed response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- HSPLIT  input  NUM_MST  OR of all slaves' split-release vectors.
- HGRANT  output  NUM_MST  one-hot grant, registered.
- HMASTER  output  MW  address-phase owner.
- HMASTERD  output  MW  data-phase owner (HMASTER delayed by one accepted cycle).
- HMASTLOCK  output  1  current address phase is locked.

## Operation
- Eligible set: HBUSREQ & ~split_mask (DEF_MST is always eligible as fallback).
- Round-robin: search starts at last_owner+1, wraps modulo NUM_MST; first eligible wins. No eligible requester -> DEF_MST.
- Arbitration point (new HGRANT computed) only when HREADY=1 and none of the following holds:
  - owner's HLOCK=1 (owner keeps the bus, HMASTLOCK follows);
  - beat counter > 1 in a fixed burst.
- Beat counter: loaded on accepted NONSEQ with HBURST INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, SINGLE/INCR=0; decrements on each accepted NONSEQ/SEQ. Accepted = HREADY=1. HTRANS=IDLE or a new NONSEQ clears/reloads it (early termination). BUSY holds it.
- Undefined-length INCR: re-arbitration allowed on any accepted beat.
- RETRY (HRESP=2, HREADY=0): owner not masked; next arbitration point uses normal round-robin.
- SPLIT: see Configuration.
- HGRANT changes may occur while the previous owner completes; HMASTER only moves on HREADY=1.

## Timing
- Reset values: HGRANT = one-hot DEF_MST, HMASTER = HMASTERD = DEF_MST, HMASTLOCK=0, split_mask=0, beat counter=0, last_owner=DEF_MST.
- Request to grant: HBUSREQ sampled at edge N -> HGRANT valid after edge N (1 cycle) if arbitration point.
- HMASTER <= index(HGRANT) on edge with HREADY=1; HMASTLOCK <= HLOCK[granted] on same edge.
- HMASTERD <= HMASTER on edge with HREADY=1; held while HREADY=0.
- Simultaneous HSPLIT release and new SPLIT on same master: set wins.
- Reset mid-burst: all state returns to reset values immediately (async), no completion.
- Owner drops HBUSREQ mid fixed burst: grant held until counter reaches 1.

## Configuration
- ARB_SPLIT_EN defined: on HRESP=SPLIT with HREADY=0 (first split cycle), set split_mask[HMASTERD]; bit cleared on edge where HSPLIT[i]=1. Masked masters are not eligible; if all requesters masked, DEF_MST is granted.
- ARB_SPLIT_EN undefined: HSPLIT ignored, split_mask constant 0, SPLIT handled as RETRY.

## Test plan
- Reset: HRESET=1 -> HGRANT=4'b0001, HMASTER=0, HMASTERD=0, HMASTLOCK=0 (NUM_MST=4, DEF_MST=0).
- Round-robin: HBUSREQ=4'b1110 constant, SINGLE NONSEQ each cycle, HREADY=1 -> HMASTER sequence 1,2,3,1,2,3.
- Fixed burst: master 2 INCR4 NONSEQ+3 SEQ with master 3 requesting, HREADY=0 on beat 2 -> HGRANT stays 4'b0100 until 4th beat accepted, then 4'b1000.
- Lock: master 1 HLOCK=1, master 3 requesting for 6 cycles -> HGRANT=4'b0010, HMASTLOCK=1 throughout; drop HLOCK -> HGRANT=4'b1000 next cycle.
- SPLIT (ARB_SPLIT_EN): master 2 gets HRESP=SPLIT -> master 2 ungranted while HBUSREQ=1; HSPLIT=4'b0100 -> master 2 regranted at next arbitration point.
- Reset mid-burst: HRESET pulse during INCR8 beat 3 -> outputs at reset values asynchronously, counter 0.
